// File: rtl/id_ex_pipe_pkg.sv
// Shared encodings for the ID/EX stage: ALU ops, jump codes and the control
// bundle that travels with each instruction, plus the all-zero bubble bundle.
package id_ex_pipe_pkg;

  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned JUMP_W  = 2;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP = 4'b0000,
    ALU_ADD = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_OR  = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_NOR = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_LUI = 4'b1011
  } alu_op_e;

  typedef enum logic [JUMP_W-1:0] {
    JMP_NONE   = 2'b00,
    JMP_JR     = 2'b01,
    JMP_JR_FWD = 2'b10,
    JMP_RSVD   = 2'b11
  } jump_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [JUMP_W-1:0]  jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    reg_dst:    1'b0,
    alu_src:    1'b0,
    alu_op:     ALU_NOP,
    jump:       JMP_NONE
  };

  // A killed slot carries the NOP bundle so nothing downstream can commit.
  function automatic ctrl_t squash_ctrl(input ctrl_t c, input logic kill);
    ctrl_t r;
    if (kill) begin
      r = CTRL_NOP;
    end else begin
      r = c;
    end
    return r;
  endfunction

  function automatic logic writes_reg(input ctrl_t c, input logic valid);
    return valid & c.reg_write;
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use compare: the load now in EX targets a register the ID instruction
// reads, so ID must wait one slot. Register 0 never creates a dependency.
module hazard_detect
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             reset_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_stall_o
);

  logic dest_live_s;
  logic src_match_s;

  // Qualify the EX load, then look for a source-operand match in ID.
  always_comb begin
    dest_live_s = ex_valid_i & ex_mem_read_i & (ex_dest_i != {REG_W{1'b0}});
    src_match_s = (ex_dest_i == id_rs_i) | (ex_dest_i == id_rt_i);
    if (reset_i) begin
      load_use_stall_o = 1'b0;
    end else begin
      load_use_stall_o = dest_live_s & src_match_s;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decoder controls and ID operands, inserts
// bubbles on flush or load-use, holds on stall_in, and counts bubbles.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               id_RegWrite,
  input  logic               id_MemToReg,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_Branch,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic [3:0]         id_ALUOp,
  input  logic [1:0]         id_Jump,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [4:0]         id_shamt,
  output logic               ex_RegWrite,
  output logic               ex_MemToReg,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_Branch,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic [3:0]         ex_ALUOp,
  output logic [1:0]         ex_Jump,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic [DATA_W-1:0]  ex_rdata1,
  output logic [DATA_W-1:0]  ex_rdata2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic [4:0]         ex_shamt,
  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_dest,
  output logic [REG_W-1:0]   previous_rd,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_t                ctrl_id_s;
  ctrl_t                ctrl_d, ctrl_q;
  logic                 valid_d, valid_q;
  logic [DATA_W-1:0]    pc4_d, pc4_q;
  logic [DATA_W-1:0]    rdata1_d, rdata1_q;
  logic [DATA_W-1:0]    rdata2_d, rdata2_q;
  logic [DATA_W-1:0]    imm_d, imm_q;
  logic [REG_W-1:0]     rs_d, rs_q;
  logic [REG_W-1:0]     rt_d, rt_q;
  logic [REG_W-1:0]     rd_d, rd_q;
  logic [SHAMT_W-1:0]   shamt_d, shamt_q;
  logic [REG_W-1:0]     dest_d, dest_q;
  logic [REG_W-1:0]     prev_d, prev_q;
  logic [CNT_W-1:0]     bcnt_d, bcnt_q;
  logic                 lus_s;
  logic                 hold_s;
  logic                 kill_s;
  logic [REG_W-1:0]     dest_id_s;

  assign ctrl_id_s = '{
    reg_write:  id_RegWrite,
    mem_to_reg: id_MemToReg,
    mem_read:   id_MemRead,
    mem_write:  id_MemWrite,
    branch:     id_Branch,
    reg_dst:    id_RegDst,
    alu_src:    id_ALUSrc,
    alu_op:     id_ALUOp,
    jump:       id_Jump
  };

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .reset_i          (reset),
    .ex_valid_i       (valid_q),
    .ex_mem_read_i    (ctrl_q.mem_read),
    .ex_dest_i        (dest_q),
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .load_use_stall_o (lus_s)
  );

  // Flush outranks stall_in; a load-use bubble waits until stall_in drops.
  always_comb begin
    hold_s    = stall_in & ~flush;
    kill_s    = flush | (~stall_in & lus_s);
    dest_id_s = id_RegDst ? id_rt : id_rd;
  end

  // Next-state of the EX register bank: hold, or load ID with optional squash.
  always_comb begin
    if (hold_s) begin
      ctrl_d   = ctrl_q;
      valid_d  = valid_q;
      pc4_d    = pc4_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      shamt_d  = shamt_q;
      dest_d   = dest_q;
    end else begin
      ctrl_d   = squash_ctrl(ctrl_id_s, kill_s);
      valid_d  = ~kill_s;
      pc4_d    = id_pc4;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
      shamt_d  = id_shamt;
      dest_d   = dest_id_s;
    end
  end

  // previous_rd is zero unless a live writer sits in EX, so r0 never forwards.
  always_comb begin
    if (writes_reg(ctrl_d, valid_d)) begin
      prev_d = dest_d;
    end else begin
      prev_d = {REG_W{1'b0}};
    end
  end

  // Saturating bubble counter for debug.
  always_comb begin
    if (kill_s && (bcnt_q != CNT_MAX)) begin
      bcnt_d = bcnt_q + CNT_ONE;
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // EX register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= CTRL_NOP;
      valid_q  <= 1'b0;
      pc4_q    <= {DATA_W{1'b0}};
      rdata1_q <= {DATA_W{1'b0}};
      rdata2_q <= {DATA_W{1'b0}};
      imm_q    <= {DATA_W{1'b0}};
      rs_q     <= {REG_W{1'b0}};
      rt_q     <= {REG_W{1'b0}};
      rd_q     <= {REG_W{1'b0}};
      shamt_q  <= {SHAMT_W{1'b0}};
      dest_q   <= {REG_W{1'b0}};
      prev_q   <= {REG_W{1'b0}};
      bcnt_q   <= {CNT_W{1'b0}};
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      pc4_q    <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      shamt_q  <= shamt_d;
      dest_q   <= dest_d;
      prev_q   <= prev_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign ex_RegWrite    = ctrl_q.reg_write;
  assign ex_MemToReg    = ctrl_q.mem_to_reg;
  assign ex_MemRead     = ctrl_q.mem_read;
  assign ex_MemWrite    = ctrl_q.mem_write;
  assign ex_Branch      = ctrl_q.branch;
  assign ex_RegDst      = ctrl_q.reg_dst;
  assign ex_ALUSrc      = ctrl_q.alu_src;
  assign ex_ALUOp       = ctrl_q.alu_op;
  assign ex_Jump        = ctrl_q.jump;
  assign ex_pc4         = pc4_q;
  assign ex_rdata1      = rdata1_q;
  assign ex_rdata2      = rdata2_q;
  assign ex_imm         = imm_q;
  assign ex_rs          = rs_q;
  assign ex_rt          = rt_q;
  assign ex_rd          = rd_q;
  assign ex_shamt       = shamt_q;
  assign ex_valid       = valid_q;
  assign ex_dest        = dest_q;
  assign previous_rd    = prev_q;
  assign load_use_stall = lus_s;
  assign bubble_count   = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the driver queues hand-computed expectations,
// a monitor pops and compares them; a CNT_W=2 copy checks counter saturation.
module tb_id_ex_pipe;

  localparam int K_LOAD = 0;
  localparam int K_HOLD = 1;
  localparam int K_BUB  = 2;
  localparam int K_RST  = 3;

  // ctrl bits: RegWrite MemToReg MemRead MemWrite Branch RegDst ALUSrc ALUOp[4] Jump[2]
  localparam logic [12:0] C_ADD = {1'b1, 6'b000000, 4'b0001, 2'b00};
  localparam logic [12:0] C_SUB = {1'b1, 6'b000000, 4'b0010, 2'b00};
  localparam logic [12:0] C_AND = {1'b1, 6'b000000, 4'b0011, 2'b00};
  localparam logic [12:0] C_LW  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 2'b00};
  localparam logic [12:0] C_SW  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 2'b00};
  localparam logic [12:0] C_JR  = {7'b0000000, 4'b0000, 2'b01};

  typedef struct packed {
    logic [12:0] ctrl;
    logic [31:0] pc4;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } id_t;

  typedef struct {
    int           cyc;
    logic         lus;
    logic         valid;
    logic [12:0]  ctrl;
    bit           chk_dest;
    logic [4:0]   dest;
    logic [4:0]   prev;
    logic [15:0]  bc;
    bit           chk_bc2;
    logic [1:0]   bc2;
    logic [147:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic stall_in = 1'b0;
  logic flush = 1'b0;
  id_t  idv = '0;

  wire [12:0] ex_ctrl, s_ctrl;
  wire [31:0] ex_pc4, ex_r1, ex_r2, ex_imm, s_pc4, s_r1, s_r2, s_imm;
  wire [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_dest, previous_rd;
  wire [4:0]  s_rs, s_rt, s_rd, s_shamt, s_dest, s_prev;
  wire        ex_valid, load_use_stall, s_valid, s_lus;
  wire [15:0] bubble_count;
  wire [1:0]  s_bc;
  wire [147:0] ex_data = {ex_pc4, ex_r1, ex_r2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt};

  id_ex_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush),
    .id_RegWrite(idv.ctrl[12]), .id_MemToReg(idv.ctrl[11]), .id_MemRead(idv.ctrl[10]),
    .id_MemWrite(idv.ctrl[9]), .id_Branch(idv.ctrl[8]), .id_RegDst(idv.ctrl[7]),
    .id_ALUSrc(idv.ctrl[6]), .id_ALUOp(idv.ctrl[5:2]), .id_Jump(idv.ctrl[1:0]),
    .id_pc4(idv.pc4), .id_rdata1(idv.r1), .id_rdata2(idv.r2), .id_imm(idv.imm),
    .id_rs(idv.rs), .id_rt(idv.rt), .id_rd(idv.rd), .id_shamt(idv.shamt),
    .ex_RegWrite(ex_ctrl[12]), .ex_MemToReg(ex_ctrl[11]), .ex_MemRead(ex_ctrl[10]),
    .ex_MemWrite(ex_ctrl[9]), .ex_Branch(ex_ctrl[8]), .ex_RegDst(ex_ctrl[7]),
    .ex_ALUSrc(ex_ctrl[6]), .ex_ALUOp(ex_ctrl[5:2]), .ex_Jump(ex_ctrl[1:0]),
    .ex_pc4(ex_pc4), .ex_rdata1(ex_r1), .ex_rdata2(ex_r2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .previous_rd(previous_rd),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  id_ex_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush),
    .id_RegWrite(idv.ctrl[12]), .id_MemToReg(idv.ctrl[11]), .id_MemRead(idv.ctrl[10]),
    .id_MemWrite(idv.ctrl[9]), .id_Branch(idv.ctrl[8]), .id_RegDst(idv.ctrl[7]),
    .id_ALUSrc(idv.ctrl[6]), .id_ALUOp(idv.ctrl[5:2]), .id_Jump(idv.ctrl[1:0]),
    .id_pc4(idv.pc4), .id_rdata1(idv.r1), .id_rdata2(idv.r2), .id_imm(idv.imm),
    .id_rs(idv.rs), .id_rt(idv.rt), .id_rd(idv.rd), .id_shamt(idv.shamt),
    .ex_RegWrite(s_ctrl[12]), .ex_MemToReg(s_ctrl[11]), .ex_MemRead(s_ctrl[10]),
    .ex_MemWrite(s_ctrl[9]), .ex_Branch(s_ctrl[8]), .ex_RegDst(s_ctrl[7]),
    .ex_ALUSrc(s_ctrl[6]), .ex_ALUOp(s_ctrl[5:2]), .ex_Jump(s_ctrl[1:0]),
    .ex_pc4(s_pc4), .ex_rdata1(s_r1), .ex_rdata2(s_r2), .ex_imm(s_imm),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_shamt(s_shamt),
    .ex_valid(s_valid), .ex_dest(s_dest), .previous_rd(s_prev),
    .load_use_stall(s_lus), .bubble_count(s_bc)
  );

  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t last;
  exp_t m;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic id_t mk(input logic [12:0] c, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] r1);
    id_t v;
    v.ctrl  = c;
    v.r1    = r1;
    v.pc4   = 32'h0040_0000 + r1;
    v.r2    = r1 ^ 32'hA5A5_A5A5;
    v.imm   = {16'hFFFF, r1[15:0]};
    v.rs    = rs;
    v.rt    = rt;
    v.rd    = rd;
    v.shamt = rd ^ 5'd1;
    return v;
  endfunction

  function automatic logic [147:0] dvec(input id_t v);
    return {v.pc4, v.r1, v.r2, v.imm, v.rs, v.rt, v.rd, v.shamt};
  endfunction

  task automatic chk(input string nm, input logic [147:0] got, input logic [147:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc_cnt, got, want);
  endtask

  // Drive one ID slot and queue what EX must show after the next edge.
  task automatic step(input id_t v, input logic rst, input logic st, input logic fl,
                      input int kind, input logic lus, input logic [4:0] dest,
                      input logic [4:0] prev, input logic [15:0] bc,
                      input bit chk_bc2, input logic [1:0] bc2);
    exp_t e;
    @(negedge clk);
    #1;
    idv = v; reset = rst; stall_in = st; flush = fl;
    e.cyc = cyc_cnt + 1; e.lus = lus; e.prev = prev; e.bc = bc;
    e.chk_bc2 = chk_bc2; e.bc2 = bc2;
    case (kind)
      K_LOAD: begin e.valid = 1'b1; e.ctrl = v.ctrl; e.chk_dest = 1'b1; e.dest = dest; e.data = dvec(v); end
      K_HOLD: begin e.valid = last.valid; e.ctrl = last.ctrl; e.chk_dest = last.chk_dest;
                    e.dest = last.dest; e.data = last.data; end
      K_BUB:  begin e.valid = 1'b0; e.ctrl = 13'd0; e.chk_dest = 1'b0; e.dest = 5'd0; e.data = dvec(v); end
      default: begin e.valid = 1'b0; e.ctrl = 13'd0; e.chk_dest = 1'b1; e.dest = 5'd0; e.data = 148'd0; end
    endcase
    last = e;
    sb.push_back(e);
  endtask

  // Monitor: registered state after each edge, load_use_stall just before it.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc == cyc_cnt) begin
      m = sb.pop_front();
      chk("ex_valid", {147'd0, ex_valid}, {147'd0, m.valid});
      chk("ex_ctrl", {135'd0, ex_ctrl}, {135'd0, m.ctrl});
      chk("previous_rd", {143'd0, previous_rd}, {143'd0, m.prev});
      chk("bubble_count", {132'd0, bubble_count}, {132'd0, m.bc});
      chk("ex_data", ex_data, m.data);
      if (m.chk_dest) chk("ex_dest", {143'd0, ex_dest}, {143'd0, m.dest});
      if (m.chk_bc2) chk("sat_count", {146'd0, s_bc}, {146'd0, m.bc2});
    end
    #3;
    if (sb.size() != 0 && sb[0].cyc == cyc_cnt + 1)
      chk("load_use_stall", {147'd0, load_use_stall}, {147'd0, sb[0].lus});
  end

  initial begin
    idv = mk(C_LW, 5'd8, 5'd8, 5'd8, 32'hDEAD);
    // reset with nonzero ID inputs
    step(mk(C_LW, 5'd8, 5'd8, 5'd8, 32'hDEAD), 1'b1, 1'b0, 1'b0, K_RST, 1'b0, 5'd0, 5'd0, 16'd0, 1'b1, 2'd0);
    // ADD pass-through, then lw r8 into EX, then dependent SUB gets one bubble
    step(mk(C_ADD, 5'd2, 5'd3, 5'd9, 32'h10), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd9, 5'd9, 16'd0, 1'b0, 2'd0);
    step(mk(C_LW, 5'd4, 5'd8, 5'd0, 32'h100), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd8, 5'd8, 16'd0, 1'b0, 2'd0);
    step(mk(C_SUB, 5'd8, 5'd2, 5'd7, 32'h20), 1'b0, 1'b0, 1'b0, K_BUB, 1'b1, 5'd0, 5'd0, 16'd1, 1'b0, 2'd0);
    step(mk(C_SUB, 5'd8, 5'd2, 5'd7, 32'h20), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd7, 5'd7, 16'd1, 1'b0, 2'd0);
    // lw r12, then rt-dependent AND under stall_in for three cycles
    step(mk(C_LW, 5'd1, 5'd12, 5'd3, 32'h200), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd12, 5'd12, 16'd1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++)
      step(mk(C_AND, 5'd1, 5'd12, 5'd13, 32'h30), 1'b0, 1'b1, 1'b0, K_HOLD, 1'b1, 5'd0, 5'd12, 16'd1, 1'b0, 2'd0);
    step(mk(C_AND, 5'd1, 5'd12, 5'd13, 32'h30), 1'b0, 1'b0, 1'b0, K_BUB, 1'b1, 5'd0, 5'd0, 16'd2, 1'b0, 2'd0);
    step(mk(C_AND, 5'd1, 5'd12, 5'd13, 32'h30), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd13, 5'd13, 16'd2, 1'b0, 2'd0);
    // load to r0 never stalls a reader of r0
    step(mk(C_LW, 5'd0, 5'd0, 5'd4, 32'h40), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd0, 5'd0, 16'd2, 1'b0, 2'd0);
    step(mk(C_ADD, 5'd0, 5'd0, 5'd5, 32'h50), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd5, 5'd5, 16'd2, 1'b0, 2'd0);
    // flush of a JR
    step(mk(C_JR, 5'd31, 5'd0, 5'd0, 32'h60), 1'b0, 1'b0, 1'b1, K_BUB, 1'b0, 5'd0, 5'd0, 16'd3, 1'b0, 2'd0);
    // flush coinciding with load-use counts one bubble
    step(mk(C_LW, 5'd3, 5'd6, 5'd0, 32'h70), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd6, 5'd6, 16'd3, 1'b0, 2'd0);
    step(mk(C_ADD, 5'd6, 5'd1, 5'd10, 32'h80), 1'b0, 1'b0, 1'b1, K_BUB, 1'b1, 5'd0, 5'd0, 16'd4, 1'b0, 2'd0);
    // store: valid but non-writing, previous_rd stays 0
    step(mk(C_SW, 5'd6, 5'd9, 5'd11, 32'h90), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd11, 5'd0, 16'd4, 1'b0, 2'd0);
    // reset during a stalled hazard wins and suppresses load_use_stall
    step(mk(C_LW, 5'd2, 5'd14, 5'd0, 32'hA0), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd14, 5'd14, 16'd4, 1'b0, 2'd0);
    step(mk(C_ADD, 5'd14, 5'd0, 5'd15, 32'hB0), 1'b1, 1'b1, 1'b0, K_RST, 1'b0, 5'd0, 5'd0, 16'd0, 1'b1, 2'd0);
    // five flushes: wide counter 1..5, 2-bit counter 1,2,3,3,3
    step(mk(C_ADD, 5'd1, 5'd2, 5'd3, 32'hC1), 1'b0, 1'b0, 1'b1, K_BUB, 1'b0, 5'd0, 5'd0, 16'd1, 1'b1, 2'd1);
    step(mk(C_ADD, 5'd1, 5'd2, 5'd3, 32'hC2), 1'b0, 1'b0, 1'b1, K_BUB, 1'b0, 5'd0, 5'd0, 16'd2, 1'b1, 2'd2);
    step(mk(C_ADD, 5'd1, 5'd2, 5'd3, 32'hC3), 1'b0, 1'b0, 1'b1, K_BUB, 1'b0, 5'd0, 5'd0, 16'd3, 1'b1, 2'd3);
    step(mk(C_ADD, 5'd1, 5'd2, 5'd3, 32'hC4), 1'b0, 1'b0, 1'b1, K_BUB, 1'b0, 5'd0, 5'd0, 16'd4, 1'b1, 2'd3);
    step(mk(C_ADD, 5'd1, 5'd2, 5'd3, 32'hC5), 1'b0, 1'b0, 1'b1, K_BUB, 1'b0, 5'd0, 5'd0, 16'd5, 1'b1, 2'd3);
    step(mk(C_ADD, 5'd1, 5'd2, 5'd3, 32'hC6), 1'b0, 1'b0, 1'b0, K_LOAD, 1'b0, 5'd3, 5'd3, 16'd5, 1'b1, 2'd3);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #4;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage MIPS core; sits directly downstream of the control decoder.
- Captures the control decoder outputs and the ID-stage operands each cycle, and presents them to EX.
- Generates load-use bubbles and exports the EX-stage destination register, which feeds the decoder's previous_rd input for JR forwarding.
- Supports stall (hold), flush (squash) and a saturating bubble counter for debug.

Parameters:
DATA_W, 32, operand/PC width
REG_W, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_in  in  1  downstream hold; EX contents frozen
flush  in  1  squash the ID instruction (taken branch/jump resolved)
id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst, id_ALUSrc  in  1 each  decoder controls
id_ALUOp  in  4  decoder ALU op
id_Jump  in  2  decoder jump code (00 none, 01 JR, 10 JR with forward)
id_pc4, id_rdata1, id_rdata2, id_imm  in  DATA_W each  PC+4, register reads, sign-extended immediate
id_rs, id_rt, id_rd  in  REG_W each  instruction register fields
id_shamt  in  5  shift amount
ex_* (all of the above except stall_in/flush)  out  same widths  registered copies
ex_valid  out  1  EX holds a real instruction
ex_dest  out  REG_W  write destination: id_rd when RegDst=0, id_rt when RegDst=1
previous_rd  out  REG_W  ex_dest if ex_valid & ex_RegWrite, else 0; drives the decoder's previous_rd
load_use_stall  out  1  combinational; upstream must hold PC and IF/ID
bubble_count  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset:
  - All ex_* outputs, ex_valid and bubble_count go to 0 on the first clk edge with reset=1; previous_rd follows to 0.
  - Reset mid-stall or mid-flush wins unconditionally.
- load_use_stall is asserted when all of the following hold:
  - ex_valid and ex_MemRead;
  - ex_dest != 0;
  - ex_dest == id_rs, or ex_dest == id_rt.
- It depends only on registered EX state and the ID fields; it is never asserted during reset.
- Per-edge priority:
  1. reset
  2. flush → bubble
  3. stall_in → hold all registers
  4. load_use_stall → bubble
  5. normal load of id_*, ex_valid=1
- Bubble:
  - All control outputs are 0 (RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc, ALUOp=0000, Jump=00), and ex_valid=0.
  - Data and field registers load the id_* values; they are don't-care but deterministic.
- Latency: one cycle from id_* to ex_*.
- A load-use stall lasts exactly one cycle, because the inserted bubble has MemRead=0.
- flush together with load_use_stall: a single bubble is inserted. Upstream also squashes, so there is no double count.
- stall_in together with load_use_stall: hold; load_use_stall stays asserted, and the bubble is inserted on the first edge where stall_in=0.
- bubble_count:
  - Increments on each edge where a bubble is loaded (flush or load-use, not reset).
  - Saturates at all-ones and does not wrap.
- previous_rd forces 0 for bubbles and non-writing instructions. Because register 0 is never forwarded, this gives no false JR forward.

Decomposition:
- Shared package: ALUOp encodings, Jump encodings (JMP_NONE=00, JMP_JR=01, JMP_JR_FWD=10), and an NOP control bundle constant used for bubbles.
- One sub-module, hazard_detect (combinational load-use compare), is natural. The register bank and counter stay in id_ex_pipe.

Test Plan:
- Reset: drive reset=1 with nonzero id_* inputs → after the edge, all ex_* are 0, ex_valid=0, bubble_count=0, previous_rd=0.
- Pass-through: ADD inputs (RegWrite=1, ALUOp=0001, RegDst=0, rd=5'd9, rdata1=32'h10) → next cycle ex_ALUOp=0001, ex_dest=9, previous_rd=9, ex_rdata1=32'h10.
- Load-use:
  - EX holds lw (MemRead=1, RegDst=1, rt=8); ID has rs=8.
  - Expect: load_use_stall=1 in that cycle; next cycle ex_valid=0 with all controls 0, and bubble_count=1.
  - The cycle after that: load_use_stall=0 and the held instruction loads.
- stall_in with load-use: stall_in=1 for 3 cycles during the hazard → EX unchanged for 3 cycles, load_use_stall held at 1, then exactly one bubble is inserted.
- Flush: flush=1 while ID holds JR (Jump=01) → ex_Jump=00, ex_valid=0, previous_rd=0, bubble_count increments.
- Saturation: CNT_W=2 with 5 consecutive flushes → bubble_count reads 1, 2, 3, 3, 3.
